// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Opcode/funct constants, ALU codes, FSM states and the
//                control-word struct shared by the MIPS control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll   = 6'h00;
    localparam logic [5:0] c_fn_srl   = 6'h02;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_nor   = 6'h27;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_or   = 4'b0001;
    localparam logic [3:0] c_alu_add  = 4'b0010;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_slt  = 4'b0111;
    localparam logic [3:0] c_alu_nor  = 4'b1100;
    localparam logic [3:0] c_alu_sll  = 4'b1000;
    localparam logic [3:0] c_alu_srl  = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       shamt_sel;
        logic [3:0] alu_control;
        logic       mem_to_reg;
        logic       is_load;
        logic       is_store;
        logic       writes_reg;
        logic       illegal;
    } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/mips_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_control_unit_if
//  Description : Fetch handshake and datapath control bundle of the MIPS
//                control unit. master = fetch/datapath side, slave = unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_control_unit_if;
    logic [31:0] Instr_In;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] Instr_Out;
    logic        Reg_Dst;
    logic        Reg_Write;
    logic        Alu_Src;
    logic        Shamt_Sel;
    logic [3:0]  Alu_Control;
    logic        Mem_Write;
    logic        Mem_Read;
    logic        Mem_To_Reg;
    logic        Done;
    logic        Illegal;

    modport master (
        output Instr_In, Instr_Valid,
        input  Instr_Ready, Instr_Out, Reg_Dst, Reg_Write, Alu_Src, Shamt_Sel,
               Alu_Control, Mem_Write, Mem_Read, Mem_To_Reg, Done, Illegal
    );

    modport slave (
        input  Instr_In, Instr_Valid,
        output Instr_Ready, Instr_Out, Reg_Dst, Reg_Write, Alu_Src, Shamt_Sel,
               Alu_Control, Mem_Write, Mem_Read, Mem_To_Reg, Done, Illegal
    );
endinterface
`default_nettype wire

// File: rtl/mips_main_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_main_decoder
//  Description : Combinational instruction -> control word decode.
//                CTRL_SHIFT_EN enables sll/srl decoding.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_word_t  o_ctrl
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    always_comb begin
        o_ctrl = '0;
        case (w_opcode)
            c_op_rtype: begin
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.writes_reg = 1'b1;
                case (w_funct)
                    c_fn_add: o_ctrl.alu_control = c_alu_add;
                    c_fn_sub: o_ctrl.alu_control = c_alu_sub;
                    c_fn_and: o_ctrl.alu_control = c_alu_and;
                    c_fn_or:  o_ctrl.alu_control = c_alu_or;
                    c_fn_nor: o_ctrl.alu_control = c_alu_nor;
                    c_fn_slt: o_ctrl.alu_control = c_alu_slt;
`ifdef CTRL_SHIFT_EN
                    c_fn_sll: begin
                        o_ctrl.alu_control = c_alu_sll;
                        o_ctrl.shamt_sel   = 1'b1;
                    end
                    c_fn_srl: begin
                        o_ctrl.alu_control = c_alu_srl;
                        o_ctrl.shamt_sel   = 1'b1;
                    end
`endif
                    default: begin
                        o_ctrl         = '0;
                        o_ctrl.illegal = 1'b1;
                    end
                endcase
                // The all-zero word retires as a NOP with no register write
                if (i_instr == 32'h0) begin
                    o_ctrl = '0;
                end
            end
            c_op_addi: begin
                o_ctrl.alu_control = c_alu_add;
                o_ctrl.alu_src     = 1'b1;
                o_ctrl.mem_to_reg  = 1'b1;
                o_ctrl.writes_reg  = 1'b1;
            end
            c_op_slti: begin
                o_ctrl.alu_control = c_alu_slt;
                o_ctrl.alu_src     = 1'b1;
                o_ctrl.mem_to_reg  = 1'b1;
                o_ctrl.writes_reg  = 1'b1;
            end
            c_op_lw: begin
                o_ctrl.alu_control = c_alu_add;
                o_ctrl.alu_src     = 1'b1;
                o_ctrl.is_load     = 1'b1;
                o_ctrl.writes_reg  = 1'b1;
            end
            c_op_sw: begin
                o_ctrl.alu_control = c_alu_add;
                o_ctrl.alu_src     = 1'b1;
                o_ctrl.is_store    = 1'b1;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_control_unit
//  Description : Multi-cycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB).
//                CTRL_SHIFT_EN (in mips_main_decoder) enables sll/srl.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
)
(
    input  logic                clk,
    input  logic                rst,
    mips_control_unit_if.slave  bus
);

    localparam logic [3:0] c_mem_last = 4'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [31:0] r_instr;
    ctrl_word_t w_dec;
    ctrl_word_t r_ctrl;
    logic [3:0] r_mem_cnt;
    logic       w_mem_last;

    logic w_ready;
    logic w_reg_write;
    logic w_mem_write;
    logic w_mem_read;
    logic w_done;
    logic w_illegal;
    logic w_sel_en;

    mips_main_decoder u_decoder (
        .i_instr (r_instr),
        .o_ctrl  (w_dec)
    );

    assign w_mem_last = (r_mem_cnt == c_mem_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_instr   <= 32'h0;
            r_ctrl    <= '0;
            r_mem_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && bus.Instr_Valid) begin
                r_instr <= bus.Instr_In;
            end
            if (r_state == ST_DECODE) begin
                r_ctrl <= w_dec;
            end
            // Counter runs only while in MEM and restarts from zero on entry
            if (r_state == ST_MEM) begin
                r_mem_cnt <= r_mem_cnt + 4'd1;
            end else begin
                r_mem_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        w_sel_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.Instr_Valid) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_dec.illegal) begin
                    w_illegal = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_sel_en = 1'b1;
                if (r_ctrl.illegal) begin
                    w_next = ST_IDLE;
                end else if (r_ctrl.is_load || r_ctrl.is_store) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                w_sel_en   = 1'b1;
                w_mem_read = r_ctrl.is_load;
                if (w_mem_last) begin
                    if (r_ctrl.is_store) begin
                        w_mem_write = 1'b1;
                        w_done      = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_sel_en    = 1'b1;
                w_reg_write = r_ctrl.writes_reg;
                w_mem_read  = r_ctrl.is_load;
                w_done      = 1'b1;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Reset silences every output in the same cycle it is asserted
        if (rst) begin
            w_ready     = 1'b0;
            w_reg_write = 1'b0;
            w_mem_write = 1'b0;
            w_mem_read  = 1'b0;
            w_done      = 1'b0;
            w_illegal   = 1'b0;
            w_sel_en    = 1'b0;
        end
    end

    assign bus.Instr_Ready = w_ready;
    assign bus.Instr_Out   = r_instr;
    assign bus.Reg_Write   = w_reg_write;
    assign bus.Mem_Write   = w_mem_write;
    assign bus.Mem_Read    = w_mem_read;
    assign bus.Done        = w_done;
    assign bus.Illegal     = w_illegal;
    assign bus.Reg_Dst     = w_sel_en & r_ctrl.reg_dst;
    assign bus.Alu_Src     = w_sel_en & r_ctrl.alu_src;
    assign bus.Shamt_Sel   = w_sel_en & r_ctrl.shamt_sel;
    assign bus.Alu_Control = w_sel_en ? r_ctrl.alu_control : 4'b0000;
    assign bus.Mem_To_Reg  = w_sel_en & r_ctrl.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_mips_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_control_unit
//  Description : Randomized self-checking bench for mips_control_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_control_unit;

    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mips_control_unit_if bus ();

    mips_control_unit #(.MEM_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       legal;
        logic       load;
        logic       store;
        logic       wr;
        logic       nop;
        logic       reg_dst;
        logic       alu_src;
        logic       shamt;
        logic       m2r;
        logic [3:0] alu;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected behaviour straight from the instruction-set table
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        e = '0;
        e.legal = 1'b1;
        op = ins[31:26];
        fn = ins[5:0];
        if (ins == 32'h0) begin
            e.nop = 1'b1;
        end else if (op == 6'h00) begin
            e.reg_dst = 1'b1; e.m2r = 1'b1; e.wr = 1'b1;
            case (fn)
                6'h20: e.alu = 4'b0010;
                6'h22: e.alu = 4'b0110;
                6'h24: e.alu = 4'b0000;
                6'h25: e.alu = 4'b0001;
                6'h27: e.alu = 4'b1100;
                6'h2A: e.alu = 4'b0111;
`ifdef CTRL_SHIFT_EN
                6'h00: begin e.alu = 4'b1000; e.shamt = 1'b1; end
                6'h02: begin e.alu = 4'b1001; e.shamt = 1'b1; end
`endif
                default: e.legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin e.alu = 4'b0010; e.alu_src = 1'b1; e.m2r = 1'b1; e.wr = 1'b1; end
                6'h0A: begin e.alu = 4'b0111; e.alu_src = 1'b1; e.m2r = 1'b1; e.wr = 1'b1; end
                6'h23: begin e.alu = 4'b0010; e.alu_src = 1'b1; e.load = 1'b1; e.wr = 1'b1; end
                6'h2B: begin e.alu = 4'b0010; e.alu_src = 1'b1; e.store = 1'b1; end
                default: e.legal = 1'b0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 13);
        case (sel)
            0:  begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
            1:  begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
            2:  begin r[31:26] = 6'h00; r[5:0] = 6'h24; end
            3:  begin r[31:26] = 6'h00; r[5:0] = 6'h25; end
            4:  begin r[31:26] = 6'h00; r[5:0] = 6'h27; end
            5:  begin r[31:26] = 6'h00; r[5:0] = 6'h2A; end
            6:  r[31:26] = 6'h08;
            7:  r[31:26] = 6'h0A;
            8:  r[31:26] = 6'h23;
            9:  r[31:26] = 6'h2B;
            10: r = 32'h0;
            11: begin r[31:26] = 6'h00; r[5:0] = 6'h00; end
            12: begin r[31:26] = 6'h00; r[5:0] = 6'h02; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic junk();
        bus.Instr_Valid = 1'($urandom_range(0, 1));
        bus.Instr_In    = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"}, {bus.Reg_Write, bus.Mem_Write, bus.Mem_Read, bus.Done, bus.Illegal}, 0);
        check({tag, "_sel"}, {bus.Reg_Dst, bus.Alu_Src, bus.Shamt_Sel, bus.Alu_Control, bus.Mem_To_Reg}, 0);
    endtask

    // Starts in an IDLE cycle, ends in the IDLE cycle after retirement
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] prev);
        exp_t e;
        int   lat;
        logic last;
        e   = model(ins);
        lat = 3 + (e.load ? 1 : 0) + ((e.load || e.store) ? MW : 0);
        bus.Instr_In    = ins;
        bus.Instr_Valid = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.Instr_Ready, 1);
        check_quiet("idle");
        check("idle_instr_out", bus.Instr_Out, prev);
        @(posedge clk); #1;
        if (!e.legal) begin
            junk();
            @(negedge clk);
            check("illegal_pulse", bus.Illegal, 1);
            check("illegal_no_strobe", {bus.Reg_Write, bus.Mem_Write, bus.Mem_Read, bus.Done, bus.Instr_Ready}, 0);
            check("illegal_instr_out", bus.Instr_Out, ins);
            @(posedge clk); #1;
        end else begin
            for (int k = 1; k <= lat; k++) begin
                junk();
                @(negedge clk);
                last = (k == lat);
                check("busy_ready", bus.Instr_Ready, 0);
                check("illegal_low", bus.Illegal, 0);
                check("done", bus.Done, last);
                check("reg_write", bus.Reg_Write, last && e.wr);
                check("mem_write", bus.Mem_Write, last && e.store);
                check("mem_read", bus.Mem_Read, e.load && k >= 3);
                check("instr_out", bus.Instr_Out, ins);
                if (!e.nop) begin
                    check("alu_control", bus.Alu_Control, (k >= 2) ? e.alu : 4'd0);
                    check("alu_src", bus.Alu_Src, (k >= 2) && e.alu_src);
                    check("shamt_sel", bus.Shamt_Sel, (k >= 2) && e.shamt);
                    if (!e.store) begin
                        check("reg_dst", bus.Reg_Dst, (k >= 2) && e.reg_dst);
                        check("mem_to_reg", bus.Mem_To_Reg, (k >= 2) && e.m2r);
                    end
                end
                @(posedge clk); #1;
            end
        end
        bus.Instr_Valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        logic [31:0] ins;
        bus.Instr_In    = 32'h0;
        bus.Instr_Valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.Instr_Valid = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.Instr_Ready, 0);
        check("rst_instr_out", bus.Instr_Out, 0);
        check_quiet("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.Instr_Valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.Instr_Ready, 1);
        @(posedge clk); #1;

        prev = 32'h0;
        // Directed cases first
        run_instr(32'h00221820, prev); prev = 32'h00221820;
        run_instr(32'h8C250008, prev); prev = 32'h8C250008;
        run_instr(32'hAC250004, prev); prev = 32'hAC250004;
        run_instr(32'hFC000000, prev); prev = 32'hFC000000;
        run_instr(32'h00011100, prev); prev = 32'h00011100;
        run_instr(32'h00000000, prev); prev = 32'h00000000;

        for (int i = 0; i < 300; i++) begin
            ins = rand_instr();
            run_instr(ins, prev);
            prev = ins;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("gap_ready", bus.Instr_Ready, 1);
                check("gap_instr_out", bus.Instr_Out, prev);
                check_quiet("gap");
                @(posedge clk); #1;
            end
        end

        // Reset during the final MEM cycle of a store
        bus.Instr_In    = 32'hAC250004;
        bus.Instr_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Instr_Valid = 1'b0;
        repeat (2 + MW) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_write", bus.Mem_Write, 0);
        check("abort_done", bus.Done, 0);
        check("abort_ready", bus.Instr_Ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", bus.Instr_Ready, 1);
        check("abort_instr_out", bus.Instr_Out, 0);
        check_quiet("abort_after");
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_stays_idle", {bus.Instr_Ready, bus.Done, bus.Mem_Write}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_control_unit.md
# mips_control_unit

Multi-cycle control unit driving the control inputs of the MIPS datapath (Reg_Dst, Reg_Write, Alu_Src, Shamt_Sel, Alu_Control, Mem_Write, Mem_Read, Mem_To_Reg). It accepts one 32-bit instruction per valid/ready handshake, holds it stable on Instr_Out, and sequences the instruction through DECODE, EXEC, MEM and WB states. Write strobes fire exactly once per instruction, and completion is reported with a one-cycle Done pulse. It sits between instruction fetch and the datapath.

## Interface
- MEM_WAIT, 0: extra MEM-state cycles for lw/sw (0..15)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- Instr_In  in  32  instruction from fetch
- Instr_Valid  in  1  Instr_In valid
- Instr_Ready  out  1  unit can accept an instruction (high only in IDLE)
- Instr_Out  out  32  latched instruction to datapath, stable until next accept
- Reg_Dst  out  1  1 = rd, 0 = rt
- Reg_Write  out  1  register-file write strobe
- Alu_Src  out  1  1 = sign-extended imm16, 0 = rt data
- Shamt_Sel  out  1  1 = zero-extended shamt as ALU input 2
- Alu_Control  out  4  ALU operation
- Mem_Write  out  1  data-memory write strobe
- Mem_Read  out  1  data-memory read enable
- Mem_To_Reg  out  1  1 = ALU result to register file, 0 = memory data
- Done  out  1  one-cycle pulse, instruction retired
- Illegal  out  1  one-cycle pulse, instruction rejected

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE:
  - Instr_Ready=1.
  - On Instr_Valid, latch Instr_In into Instr_Out and go to DECODE.
- DECODE:
  - Decode Instr_Out into a control word, registered at the end of DECODE.
  - If illegal: Illegal=1 this cycle, go to IDLE, no strobes fire.
  - Otherwise go to EXEC.
- EXEC: mux selects and Alu_Control are valid. Then:
  - lw/sw go to MEM.
  - All others go to WB.
- MEM:
  - Lasts 1+MEM_WAIT cycles, counted by a 4-bit counter.
  - Mem_Read=1 throughout for lw.
  - For sw, Mem_Write=1 only in the last MEM cycle, with Done=1 in that same cycle; then go to IDLE.
  - lw goes to WB.
- WB: Reg_Write=1 and Done=1 for one cycle, then go to IDLE. For lw, Mem_Read stays high in WB.
- Decode table (R-type opcode 0x00 by funct; others by opcode):
  - add 0x20: ADD
  - sub 0x22: SUB
  - and 0x24: AND
  - or 0x25: OR
  - nor 0x27: NOR
  - slt 0x2A: SLT
  - R-type settings: Reg_Dst=1, Alu_Src=0, Mem_To_Reg=1.
  - addi 0x08 (ADD) and slti 0x0A (SLT): Reg_Dst=0, Alu_Src=1, Mem_To_Reg=1.
  - lw 0x23: ADD, Alu_Src=1, Reg_Dst=0, Mem_To_Reg=0.
  - sw 0x2B: ADD, Alu_Src=1, no register write.
  - Everything else is illegal.
- Alu_Control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1000, SRL 1001.
- Instruction 32'h0 is a NOP: it runs DECODE, EXEC, WB with Done=1 and Reg_Write=0.
- Select outputs (Reg_Dst, Alu_Src, Shamt_Sel, Alu_Control, Mem_To_Reg) hold their values from EXEC through the final state. They return to 0 in IDLE.

## Timing
- Reset: state IDLE. All outputs 0, including Instr_Out=0 and Instr_Ready=0 during reset. Instr_Ready=1 the first cycle after rst deasserts.
- rst mid-instruction aborts at the next edge: no further strobe, no Done.
- Instr_Valid outside IDLE is ignored; the instruction is not captured.
- Cycles from accept edge to Done cycle, MEM_WAIT=0:
  - R-type, I-ALU and NOP: 3.
  - sw: 3.
  - lw: 4.
  - MEM_WAIT adds N cycles to lw/sw.
- Illegal asserts 1 cycle after accept.
- Back-to-back throughput, MEM_WAIT=0: 4 cycles per R/sw instruction, 5 per lw. Instr_Ready rises the cycle after Done/Illegal.
- Reg_Write, Mem_Write, Done and Illegal are never high for more than one cycle per instruction.

## Configuration
- CTRL_SHIFT_EN defined:
  - funct 0x00 (sll) and 0x02 (srl) decode as SLL/SRL with Shamt_Sel=1, Reg_Dst=1, Mem_To_Reg=1.
  - 32'h0 still runs as a NOP with Reg_Write=0.
- CTRL_SHIFT_EN undefined:
  - Shamt_Sel is tied 0.
  - funct 0x00/0x02 are illegal, except 32'h0, which is a NOP.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - Alu_Control codes
  - state encoding
  - the control-word struct (sel fields plus is_load/is_store/writes_reg/illegal)
- Sub-module mips_main_decoder: purely combinational mapping from the 32-bit instruction to the control word.
- The FSM, MEM_WAIT counter and output registers live in mips_control_unit.

## Test plan
- add $3,$1,$2 (32'h00221820), Instr_Valid one cycle → Reg_Dst=1, Alu_Control=0010, Mem_To_Reg=1, Reg_Write high only in cycle 3, Done in cycle 3.
- lw $5,8($1) (32'h8C250008), MEM_WAIT=2 → Mem_Read high cycles 3–6, Mem_To_Reg=0, Reg_Write+Done in cycle 6.
- sw $5,4($1) (32'hAC250004), MEM_WAIT=0 → Mem_Write+Done in cycle 3, Reg_Write never high.
- opcode 0x3F (32'hFC000000) → Illegal in cycle 1, no strobes, Instr_Ready=1 in cycle 2.
- sll $2,$1,4 (32'h00011100) → with CTRL_SHIFT_EN: Shamt_Sel=1, Alu_Control=1000, Done cycle 3. Without it: Illegal.
- rst asserted during the MEM cycle of sw → no Mem_Write, no Done. After release, all outputs 0 and Instr_Ready=1.
